// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/exec/halt control FSM for a tiny CPU.
// Define CPU_SEQ_STEP_EN to add a single-step port and wait state.
module cpu_sequencer #(
  parameter int PC_WIDTH = 5,
  parameter int MUL_LAT  = 2
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                start,
`ifdef CPU_SEQ_STEP_EN
  input  logic                step,
`endif
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         ir,
  output logic                exec_en,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_STEP
  } state_e;

  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [3:0] LAT_M1  = 4'(MUL_LAT - 1);

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [31:0]         ir_q;
  logic [3:0]          cnt_q;
  logic                req_q;
  logic                exec_en_q;
  logic                busy_q;
  logic                done_q;
  logic                illegal_q;
  logic [4:0]          opcode;
  logic                is_exec;
  logic                is_mul;
  logic                is_halt;

  always_comb begin
    opcode  = ir_q[31:27];
    is_exec = (opcode <= OP_MUL);
    is_mul  = (opcode == OP_MUL);
    is_halt = (opcode == OP_HALT);
    pc_d    = pc_q + PC_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      exec_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      exec_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            req_q     <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
            ir_q    <= imem_data;
            req_q   <= 1'b0;
          end
        end
        S_DECODE: begin
          if (is_exec) begin
            state_q   <= S_EXEC;
            exec_en_q <= 1'b1;
            cnt_q     <= is_mul ? LAT_M1 : 4'd0;
          end else begin
            state_q   <= S_HALT;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            illegal_q <= !is_halt;
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            pc_q <= pc_d;
`ifdef CPU_SEQ_STEP_EN
            state_q <= S_STEP;
            busy_q  <= 1'b0;
`else
            state_q <= S_FETCH;
            req_q   <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef CPU_SEQ_STEP_EN
        S_STEP: begin
          if (step) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign exec_en   = exec_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer (PC_WIDTH=2, MUL_LAT=3).
// Memory responder acks after ack_dly FETCH cycles.
module tb_cpu_sequencer;

  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic [31:0]   ir;
  logic          exec_en;
  logic          busy;
  logic          done;
  logic          illegal;

  logic [31:0] mem [4];
  int          ack_dly;
  int          fcnt;
  logic        force_ack;
  int          ex_cnt;
  int          n_cmp;
  int          n_err;

  cpu_sequencer #(.PC_WIDTH(PW), .MUL_LAT(3)) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .ir       (ir),
    .exec_en  (exec_en),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    imem_data = mem[imem_addr];
    if (imem_req) begin
      imem_ack = force_ack || (fcnt == ack_dly);
      fcnt++;
    end else begin
      imem_ack = force_ack;
      fcnt = 0;
    end
    @(posedge clk);
    #1;
    if (exec_en) ex_cnt++;
  endtask

  task automatic run_to_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ex_cnt = 0;
    ack_dly = 0; fcnt = 0; force_ack = 1'b0;
    sys_rst = 1'b1; start = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    for (int i = 0; i < 4; i++) mem[i] = 32'hF800_0000;
    tick(); tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_flags", {28'd0, exec_en, busy, done, illegal}, 32'd0);

    // basic add then halt
    sys_rst = 1'b0;
    mem[0] = 32'h1000_0001;
    mem[1] = 32'hF800_0000;
    tick();
    chk("idle_hold", {30'd0, busy, imem_req}, 32'd0);
    ex_cnt = 0;
    pulse_start();
    chk("f_req", {30'd0, imem_req, busy}, 32'd3);
    chk("f_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("d_ir", ir, 32'h1000_0001);
    chk("d_flags", {30'd0, exec_en, imem_req}, 32'd0);
    tick();
    chk("ex_en", 32'(exec_en), 32'd1);
    tick();
    chk("ex_exit", {30'd0, exec_en, imem_req}, 32'd1);
    chk("pc1", 32'(imem_addr), 32'd1);
    tick(); tick();
    chk("h_flags", {29'd0, busy, done, illegal}, 32'd2);
    chk("h_pc", 32'(imem_addr), 32'd1);
    chk("h_excnt", ex_cnt, 32'd1);
    tick(); tick();
    chk("h_hold_ir", ir, 32'hF800_0000);
    chk("h_hold_pc", 32'(imem_addr), 32'd1);

    // mul with MUL_LAT=3
    mem[0] = 32'h2000_0000;
    ex_cnt = 0;
    pulse_start();
    tick();
    chk("m_dec_ir", ir, 32'h2000_0000);
    tick();
    chk("m_ex1", {29'd0, exec_en, busy, imem_req}, 32'd6);
    tick();
    chk("m_ex2", {29'd0, exec_en, busy, imem_req}, 32'd2);
    tick();
    chk("m_ex3", {29'd0, exec_en, busy, imem_req}, 32'd2);
    tick();
    chk("m_fetch", {31'd0, imem_req}, 32'd1);
    chk("m_pc", 32'(imem_addr), 32'd1);
    chk("m_excnt", ex_cnt, 32'd1);
    run_to_done("m_halt");

    // delayed ack, start held high during the wait
    mem[0] = 32'h0800_0000;
    ack_dly = 4;
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dl_req", 32'(imem_req), 32'd1);
      chk("dl_addr", 32'(imem_addr), 32'd0);
      chk("dl_ir", ir, 32'hF800_0000);
    end
    start = 1'b0;
    tick();
    chk("dl_ack_ir", ir, 32'h0800_0000);
    chk("dl_ack_req", 32'(imem_req), 32'd0);
    ack_dly = 0;
    run_to_done("dl_halt");

    // undefined opcode
    mem[0] = 32'h5000_0000;
    ex_cnt = 0;
    pulse_start();
    tick(); tick();
    chk("il_flags", {29'd0, busy, done, illegal}, 32'd3);
    chk("il_excnt", ex_cnt, 32'd0);
    mem[0] = 32'hF800_0000;
    pulse_start();
    chk("il_clr", {29'd0, done, illegal, imem_req}, 32'd1);
    chk("il_addr", 32'(imem_addr), 32'd0);
    run_to_done("il_halt");
    chk("il_after", 32'(illegal), 32'd0);

    // pc wrap with 2-bit pc
    mem[0] = 32'h0000_0123;
    mem[1] = 32'h0800_0000;
    mem[2] = 32'h1000_0000;
    mem[3] = 32'h1800_0000;
    ex_cnt = 0;
    pulse_start();
    for (int i = 0; i < 9; i++) tick();
    chk("w_pc3", 32'(imem_addr), 32'd3);
    tick(); tick(); tick();
    chk("w_pc0", 32'(imem_addr), 32'd0);
    chk("w_req", 32'(imem_req), 32'd1);
    chk("w_excnt", ex_cnt, 32'd4);
    tick();
    chk("w_ir", ir, 32'h0000_0123);

    // reset in second mul EXEC cycle
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    mem[0] = 32'h2000_0000;
    pulse_start();
    tick(); tick();
    chk("r_ex1", 32'(exec_en), 32'd1);
    tick();
    chk("r_ex2", {30'd0, busy, exec_en}, 32'd2);
    ex_cnt = 0;
    sys_rst = 1'b1;
    start = 1'b1;
    force_ack = 1'b1;
    tick();
    chk("r_flags", {28'd0, exec_en, busy, done, illegal}, 32'd0);
    chk("r_req", 32'(imem_req), 32'd0);
    chk("r_addr", 32'(imem_addr), 32'd0);
    chk("r_ir", ir, 32'd0);
    sys_rst = 1'b0;
    start = 1'b0;
    tick(); tick();
    chk("r_idle", {29'd0, busy, imem_req, exec_en}, 32'd0);
    chk("r_ack_ign", ir, 32'd0);
    chk("r_excnt", ex_cnt, 32'd0);
    force_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 5: program counter and instruction address width.
REQ-002 Parameter MUL_LAT, default 2, legal range 1..15: EXEC cycles held for mul opcode 5'b00100.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  launch or relaunch program execution from address 0.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  PC_WIDTH  fetch address; equals pc.
REQ-008 imem_ack  input  1  fetch data valid this cycle.
REQ-009 imem_data  input  32  instruction word.
REQ-010 ir  output  32  latched instruction word driven to datapath.
REQ-011 exec_en  output  1  one-cycle strobe telling the datapath to execute ir.
REQ-012 busy  output  1  high in FETCH, DECODE and EXEC.
REQ-013 done  output  1  high in HALT.
REQ-014 illegal  output  1  high in HALT when halt was caused by an undefined opcode.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, DECODE, EXEC and HALT; opcode field is ir[31:27].
REQ-016 IDLE: start=1 SHALL set pc=0 and enter FETCH on the next edge; start=0 SHALL hold IDLE.
REQ-017 FETCH: imem_req SHALL be 1 every cycle; the cycle imem_ack=1, ir SHALL load imem_data and the state SHALL become DECODE; imem_ack outside FETCH SHALL be ignored.
REQ-018 DECODE (1 cycle): opcode 5'b00000..5'b00100 SHALL go to EXEC; 5'b11111 SHALL go to HALT with illegal=0; any other opcode SHALL go to HALT with illegal=1.
REQ-019 EXEC: exec_en SHALL be 1 only in the first EXEC cycle; non-mul opcodes SHALL stay in EXEC 1 cycle; mul SHALL stay MUL_LAT cycles, counted by an internal counter.
REQ-020 On EXEC exit, pc SHALL increment by 1 (mod 2^PC_WIDTH, so all-ones wraps to 0) and the state SHALL become FETCH.
REQ-021 Minimum instruction period with imem_ack in the first FETCH cycle SHALL be 3 cycles for non-mul and 2+MUL_LAT for mul.
REQ-022 HALT: done=1, pc and ir SHALL hold; start=1 SHALL clear illegal, set pc=0 and enter FETCH.
REQ-023 start SHALL be ignored in FETCH, DECODE and EXEC.
REQ-024 ir SHALL change only on an acknowledged fetch, so ir is stable throughout DECODE and EXEC.

Reset
REQ-025 sys_rst=1 SHALL force IDLE, pc=0, ir=0, exec_en=0, imem_req=0, busy=0, done=0, illegal=0 and clear the MUL_LAT counter at that edge.
REQ-026 Reset SHALL take priority over every event, including start and imem_ack in the same cycle.
REQ-027 Reset in any state, including mid-EXEC, SHALL abort the instruction without a further exec_en.

Configuration
REQ-028 Macro CPU_SEQ_STEP_EN SHALL select single-step mode.
REQ-029 With CPU_SEQ_STEP_EN defined: add input step (1 bit); the FSM SHALL wait after EXEC exit, with pc already incremented, until step=1 before entering FETCH; done stays 0 while waiting.
REQ-030 Without CPU_SEQ_STEP_EN: there is no step port and EXEC exit enters FETCH directly.

Verification
REQ-031 Reset, then start pulse, memory {add 0x10000001... (opcode 00010), 0xF8000000}, acks immediate -> exec_en pulses once at cycle 3 after start, done=1 with pc=1, illegal=0.
REQ-032 Mul instruction (ir[31:27]=00100) with MUL_LAT=3 -> exec_en high 1 cycle, EXEC lasts 3 cycles, next imem_req 4 cycles after DECODE.
REQ-033 imem_ack delayed 4 cycles -> imem_req held high 4 cycles, imem_addr stable, ir unchanged until ack cycle.
REQ-034 Opcode 5'b01010 -> HALT with illegal=1, no exec_en; start -> illegal=0, imem_addr=0.
REQ-035 PC_WIDTH=2, four non-halt instructions -> after 4th EXEC pc wraps to 0, fetch from address 0.
REQ-036 sys_rst asserted in second EXEC cycle of mul with start=1 and imem_ack=1 the same cycle -> next cycle IDLE, all outputs 0, no exec_en.
